// File: rtl/ds_dram_master_if.sv
// Data-memory port bundle between the downsampling master and the memory.
// Master drives address/strobes/handshake requests; slave returns read data and load/dump completion.
interface ds_dram_master_if;
    logic [15:0] dram_addr;
    logic        dram_read;
    logic        dram_write;
    logic [7:0]  dram_wdata;
    logic [7:0]  dram_rdata;
    logic        dram_rd_en;
    logic        dram_rd_done;
    logic        dram_wr_en;
    logic        dram_wr_done;

    modport master (
        output dram_addr, dram_read, dram_write, dram_wdata, dram_rd_en, dram_wr_en,
        input  dram_rdata, dram_rd_done, dram_wr_done
    );

    modport slave (
        input  dram_addr, dram_read, dram_write, dram_wdata, dram_rd_en, dram_wr_en,
        output dram_rdata, dram_rd_done, dram_wr_done
    );
endinterface

// File: rtl/ds_dram_master.sv
// 2:1 image downsampler master: load handshake, 2x2 block average written in place, dump handshake.
// Optional build macro DS_ROUND_EN selects round-half-up averaging instead of truncation.
module ds_dram_master #(
    parameter int unsigned IMG_W    = 256,
    parameter int unsigned IMG_H    = 256,
    parameter logic [15:0] SRC_BASE = 16'h0000,
    parameter logic [15:0] DST_BASE = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    ds_dram_master_if.master   dram
);
    localparam int unsigned HALF_W = IMG_W / 2;
    localparam int unsigned HALF_H = IMG_H / 2;
    localparam int unsigned CW     = $clog2(HALF_W + 1);
    localparam int unsigned RW     = $clog2(HALF_H + 1);
    localparam logic [15:0] W16    = 16'(IMG_W);
    localparam logic [15:0] ROW_STEP = 16'(2 * IMG_W);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_R0, S_R1, S_R2, S_R3, S_ACC, S_WR, S_DUMP, S_FIN
    } state_e;

    state_e        state_q;
    logic          busy_q, done_q, first_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [15:0]   row_base_q, src_q, dst_q;
    logic [9:0]    acc_q;
    logic [15:0]   addr_q;
    logic          read_q, write_q, rd_en_q, wr_en_q;
    logic [7:0]    wdata_q;

    logic [9:0]    acc_d;
    logic [7:0]    avg_d;
    logic [15:0]   row_base_d, src_d;
    logic          last_col, last_row;

    assign acc_d      = acc_q + 10'(dram.dram_rdata);
`ifdef DS_ROUND_EN
    logic [9:0] acc_rnd;
    assign acc_rnd    = acc_d + 10'd2;
    assign avg_d      = 8'(acc_rnd >> 2);
`else
    assign avg_d      = 8'(acc_d >> 2);
`endif
    assign last_col   = (col_q == CW'(HALF_W - 1));
    assign last_row   = (row_q == RW'(HALF_H - 1));
    assign row_base_d = row_base_q + ROW_STEP;
    // Source pointer for the block after the current one
    assign src_d      = last_col ? row_base_d : src_q + 16'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            first_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            acc_q      <= '0;
            addr_q     <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_q    <= S_LOAD;
                    busy_q     <= 1'b1;
                    done_q     <= 1'b0;
                    rd_en_q    <= 1'b1;
                    first_q    <= 1'b1;
                    col_q      <= '0;
                    row_q      <= '0;
                    row_base_q <= SRC_BASE;
                    src_q      <= SRC_BASE;
                    dst_q      <= DST_BASE;
                    acc_q      <= '0;
                end
                // The first LOAD cycle never samples, so a stale sticky done costs one cycle
                S_LOAD: begin
                    first_q <= 1'b0;
                    if (!first_q && dram.dram_rd_done) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_R0;
                        read_q  <= 1'b1;
                        addr_q  <= src_q;
                    end
                end
                S_R0: begin
                    acc_q   <= '0;
                    state_q <= S_R1;
                    read_q  <= 1'b1;
                    addr_q  <= src_q + 16'd1;
                end
                S_R1: begin
                    acc_q   <= acc_d;
                    state_q <= S_R2;
                    read_q  <= 1'b1;
                    addr_q  <= src_q + W16;
                end
                S_R2: begin
                    acc_q   <= acc_d;
                    state_q <= S_R3;
                    read_q  <= 1'b1;
                    addr_q  <= src_q + W16 + 16'd1;
                end
                S_R3: begin
                    acc_q   <= acc_d;
                    state_q <= S_ACC;
                end
                // Last pixel arrives now; average the complete sum straight into the write data
                S_ACC: begin
                    acc_q   <= acc_d;
                    state_q <= S_WR;
                    write_q <= 1'b1;
                    addr_q  <= dst_q;
                    wdata_q <= avg_d;
                end
                S_WR: begin
                    dst_q <= dst_q + 16'd1;
                    src_q <= src_d;
                    if (last_col) begin
                        col_q      <= '0;
                        row_q      <= row_q + RW'(1);
                        row_base_q <= row_base_d;
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                    if (last_col && last_row) begin
                        state_q <= S_DUMP;
                        wr_en_q <= 1'b1;
                        first_q <= 1'b1;
                    end else begin
                        state_q <= S_R0;
                        read_q  <= 1'b1;
                        addr_q  <= src_d;
                    end
                end
                S_DUMP: begin
                    first_q <= 1'b0;
                    if (!first_q && dram.dram_wr_done) begin
                        wr_en_q <= 1'b0;
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign dram.dram_addr  = addr_q;
    assign dram.dram_read  = read_q;
    assign dram.dram_write = write_q;
    assign dram.dram_wdata = wdata_q;
    assign dram.dram_rd_en = rd_en_q;
    assign dram.dram_wr_en = wr_en_q;
endmodule

// File: tb/tb_ds_dram_master.sv
// Bench for ds_dram_master on a 4x4 image: memory and handshake responder models plus
// a block-average reference computed from the source image.
module tb_ds_dram_master;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned NB = (W / 2) * (H / 2);

    logic clk = 1'b0;
    logic rst_n, start, busy, done;

    ds_dram_master_if dram_if();

    ds_dram_master #(.IMG_W(W), .IMG_H(H), .SRC_BASE(16'h0000), .DST_BASE(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .dram(dram_if)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, cyc = 0;
    logic [7:0] mem [0:65535];
    logic [7:0] img [W*H];
    int exp_px [NB];

    int rd_dly = 2, wr_dly = 2, rd_cnt = 0, wr_cnt = 0;
    bit rd_stk = 0, wr_stk = 0;

    int rd_first, rd_len, wr_first, wr_len, first_rd, done_rise, done_cyc;
    bit prev_re = 0, prev_we = 0, prev_done = 0;
    int wl_addr[$], wl_data[$], wl_cyc[$];

    always @(posedge clk) cyc++;

    // Registered-read memory
    always @(posedge clk) begin
        if (dram_if.dram_read)  dram_if.dram_rdata <= mem[dram_if.dram_addr];
        if (dram_if.dram_write) mem[dram_if.dram_addr] = dram_if.dram_wdata;
    end

    // Load/dump responders: done appears during the Nth cycle of the request
    always @(negedge clk) begin
        if (dram_if.dram_rd_en) begin
            rd_cnt++;
            if (rd_cnt >= rd_dly) dram_if.dram_rd_done = 1'b1;
        end else begin
            rd_cnt = 0;
            if (!rd_stk) dram_if.dram_rd_done = 1'b0;
        end
        if (dram_if.dram_wr_en) begin
            wr_cnt++;
            if (wr_cnt >= wr_dly) dram_if.dram_wr_done = 1'b1;
        end else begin
            wr_cnt = 0;
            if (!wr_stk) dram_if.dram_wr_done = 1'b0;
        end
    end

    // Monitor: strobe exclusivity every cycle plus timing statistics
    always @(negedge clk) begin
        vectors++;
        assert (!(dram_if.dram_read && dram_if.dram_write) &&
                !((dram_if.dram_read || dram_if.dram_write) && (dram_if.dram_rd_en || dram_if.dram_wr_en)) &&
                !(dram_if.dram_rd_en && dram_if.dram_wr_en))
        else begin
            miscompares++;
            $error("FAIL strobe_excl: rd=%0b wr=%0b rd_en=%0b wr_en=%0b, required mutually exclusive",
                   dram_if.dram_read, dram_if.dram_write, dram_if.dram_rd_en, dram_if.dram_wr_en);
        end
        if (dram_if.dram_rd_en) begin
            if (!prev_re) rd_first = cyc;
            rd_len++;
        end
        if (dram_if.dram_wr_en) begin
            if (!prev_we) wr_first = cyc;
            wr_len++;
        end
        if (dram_if.dram_read && first_rd < 0) first_rd = cyc;
        if (dram_if.dram_write) begin
            wl_addr.push_back(int'(dram_if.dram_addr));
            wl_data.push_back(int'(dram_if.dram_wdata));
            wl_cyc.push_back(cyc);
        end
        if (done && !prev_done) begin
            done_rise++;
            done_cyc = cyc;
        end
        prev_re   = dram_if.dram_rd_en;
        prev_we   = dram_if.dram_wr_en;
        prev_done = done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int avg4(int a, int b, int c, int d);
`ifdef DS_ROUND_EN
        return (a + b + c + d + 2) / 4;
`else
        return (a + b + c + d) / 4;
`endif
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic clear_stats();
        rd_first = -1; rd_len = 0; wr_first = -1; wr_len = 0;
        first_rd = -1; done_rise = 0; done_cyc = -1;
        wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
    endtask

    task automatic rand_img();
        for (int i = 0; i < W*H; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic load_mem();
        for (int i = 0; i < W*H; i++) mem[i] = img[i];
        for (int br = 0; br < H/2; br++)
            for (int bc = 0; bc < W/2; bc++) begin
                int base;
                base = 2*br*W + 2*bc;
                exp_px[br*(W/2) + bc] = avg4(img[base], img[base+1], img[base+W], img[base+W+1]);
            end
    endtask

    task automatic run_img(input int rd_n, input int wr_n, input bit rs, input bit ws, input int mid_start);
        bit pre_rd, pre_wr, got;
        int start_cyc, bad;
        rd_dly = rd_n; wr_dly = wr_n; rd_stk = rs; wr_stk = ws;
        repeat (2) @(negedge clk);
        pre_rd = dram_if.dram_rd_done;
        pre_wr = dram_if.dram_wr_done;
        load_mem();
        clear_stats();
        start = 1'b1;
        start_cyc = cyc;
        got = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            start = (t == mid_start);
            if (done) begin got = 1; break; end
        end
        start = 1'b0;
        chk("done_reached", 32'(got), 1);
        repeat (3) @(negedge clk);
        chk("rd_en_first", rd_first, start_cyc + 1);
        chk("rd_en_len", rd_len, pre_rd ? 2 : imax(rd_n, 2));
        chk("first_read", first_rd, rd_first + (pre_rd ? 2 : imax(rd_n, 2)));
        chk("n_writes", wl_addr.size(), NB);
        for (int i = 0; i < NB && i < wl_addr.size(); i++) begin
            chk("wr_addr", wl_addr[i], i);
            chk("wr_data", wl_data[i], exp_px[i]);
            chk("wr_cycle", wl_cyc[i] - first_rd, 5 + 6*i);
        end
        if (wl_cyc.size() > 0) chk("dump_start", wr_first, wl_cyc[wl_cyc.size()-1] + 1);
        chk("dump_len", wr_len, pre_wr ? 2 : imax(wr_n, 2));
        chk("done_cycle", done_cyc, wr_first + (pre_wr ? 2 : imax(wr_n, 2)));
        chk("done_rises", done_rise, 1);
        chk("busy_after", 32'(busy), 0);
        chk("done_level", 32'(done), 1);
        bad = 0;
        for (int i = 0; i < W*H; i++)
            if (int'(mem[i]) != ((i < NB) ? exp_px[i] : int'(img[i]))) bad++;
        chk("mem_image", bad, 0);
    endtask

    function automatic logic [31:0] outs_packed();
        return {2'b0, busy, done, dram_if.dram_addr, dram_if.dram_read, dram_if.dram_write,
                dram_if.dram_wdata[1:0] | {1'b0, |dram_if.dram_wdata[7:2]},
                dram_if.dram_rd_en, dram_if.dram_wr_en};
    endfunction

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        clear_stats();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(dram_if.dram_addr), 0);
        chk("rst_read", 32'(dram_if.dram_read), 0);
        chk("rst_write", 32'(dram_if.dram_write), 0);
        chk("rst_wdata", 32'(dram_if.dram_wdata), 0);
        chk("rst_rd_en", 32'(dram_if.dram_rd_en), 0);
        chk("rst_wr_en", 32'(dram_if.dram_wr_en), 0);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_quiet", outs_packed(), 0);
        end

        // Directed image: exact block averages 15, 35, 55, 75
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r*W + c] = 8'((r < 2 ? 10 : 50) + 10*c);
        run_img(3, 3, 0, 0, -1);
        if (wl_data.size() == NB) begin
            chk("dir_px0", wl_data[0], 15);
            chk("dir_px3", wl_data[3], 75);
        end

        // Rounding block {1,2,2,2} and saturated block of 255s
        rand_img();
        img[0] = 8'd1;   img[1] = 8'd2;   img[W] = 8'd2;   img[W+1] = 8'd2;
        img[2] = 8'd255; img[3] = 8'd255; img[W+2] = 8'd255; img[W+3] = 8'd255;
        run_img(2, 4, 0, 0, -1);
        if (wl_data.size() >= 2) begin
`ifdef DS_ROUND_EN
            chk("round_blk", wl_data[0], 2);
`else
            chk("round_blk", wl_data[0], 1);
`endif
            chk("sat_blk", wl_data[1], 255);
        end

        // Slow load handshake, then a run with rd_done left sticky
        rand_img(); run_img(11, 2, 1, 0, -1);
        rand_img(); run_img(5, 2, 1, 0, -1);

        // start pulsed mid-processing is ignored
        rand_img(); run_img(2, 2, 0, 0, 15);

        // Mid-run reset during R2 of block 1
        rand_img(); load_mem(); clear_stats();
        rd_dly = 2; rd_stk = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        for (int t = 0; t < 200; t++) begin
            if (dram_if.dram_read) k++;
            if (k == 7) break;
            @(negedge clk);
        end
        chk("reached_r2", k, 7);
        rst_n = 1'b0;
        #1;
        chk("abort_read", 32'(dram_if.dram_read), 0);
        chk("abort_outs", outs_packed(), 0);
        repeat (3) @(negedge clk);
        chk("abort_writes", wl_addr.size(), 1);
        rst_n = 1'b1;
        run_img(3, 3, 0, 1, -1);
        rand_img(); run_img(4, 6, 0, 1, -1);

        // Randomized handshake delays and images
        for (int n = 0; n < 6; n++) begin
            rand_img();
            run_img(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    (n == 3) ? 20 : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
